// File: rtl/sram_cpu_bridge.sv
// Bridges the PicoRV32 native memory port onto the SRAM adapter start/busy/done port.
// Optional macro SRAM_POSTED_WRITE_EN acknowledges in-range writes in the cycle the start pulse is issued.
module sram_cpu_bridge #(
    parameter logic [31:0] ADDR_BASE      = 32'h0000_0000,
    parameter logic [31:0] ADDR_SIZE      = 32'h0008_0000,
    parameter int          TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        mem_valid,
    input  logic        mem_instr,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic        start,
    output logic [7:0]  cmd,
    output logic [31:0] addr_out,
    output logic [31:0] data_out,
    output logic [3:0]  wstrb_out,
    input  logic        busy,
    input  logic        done,
    input  logic [31:0] result,
    output logic        oor_err,
    output logic        timeout_err
);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESP, DRAIN} state_t;

    localparam logic [7:0]  CMD_WRITE = 8'h02;
    localparam logic [7:0]  CMD_READ  = 8'h03;
    localparam logic [32:0] WIN_LO    = {1'b0, ADDR_BASE};
    localparam logic [32:0] WIN_HI    = {1'b0, ADDR_BASE} + {1'b0, ADDR_SIZE};
    // WAIT starts one cycle after start, so the last waiting cycle is counter value TIMEOUT_CYCLES-2
    localparam logic [15:0] WD_LAST   = (TIMEOUT_CYCLES >= 2) ? 16'(TIMEOUT_CYCLES - 2) : 16'd0;

`ifdef SRAM_POSTED_WRITE_EN
    localparam bit POSTED_EN = 1'b1;
`else
    localparam bit POSTED_EN = 1'b0;
`endif

    state_t      state_q, state_d;
    logic [15:0] wd_q, wd_d;
    logic        posted_q, posted_d;

    logic        mem_ready_d, start_d, oor_err_d, timeout_err_d;
    logic [31:0] mem_rdata_d, addr_out_d, data_out_d;
    logic [7:0]  cmd_d;
    logic [3:0]  wstrb_out_d;

    logic        in_range;
    logic        is_write;
    logic        expire;

    logic unused_inputs;
    assign unused_inputs = ^{mem_instr, busy};

    assign in_range = ({1'b0, mem_addr} >= WIN_LO) && ({1'b0, mem_addr} < WIN_HI);
    assign is_write = |mem_wstrb;

    always_comb begin
        state_d       = state_q;
        wd_d          = wd_q;
        posted_d      = posted_q;
        mem_ready_d   = 1'b0;
        start_d       = 1'b0;
        oor_err_d     = 1'b0;
        timeout_err_d = 1'b0;
        mem_rdata_d   = mem_rdata;
        addr_out_d    = addr_out;
        data_out_d    = data_out;
        cmd_d         = cmd;
        wstrb_out_d   = wstrb_out;
        expire        = 1'b0;

        case (state_q)
            IDLE: begin
                // A request still high during its own acknowledge cycle is the one just served
                if (mem_valid && !mem_ready) begin
                    if (in_range) begin
                        addr_out_d  = mem_addr - ADDR_BASE;
                        data_out_d  = mem_wdata;
                        wstrb_out_d = mem_wstrb;
                        cmd_d       = is_write ? CMD_WRITE : CMD_READ;
                        start_d     = 1'b1;
                        posted_d    = POSTED_EN && is_write;
                        if (POSTED_EN && is_write) begin
                            mem_ready_d = 1'b1;
                            mem_rdata_d = 32'h0;
                        end
                        state_d = ISSUE;
                    end else begin
                        mem_ready_d = 1'b1;
                        mem_rdata_d = 32'h0;
                        oor_err_d   = 1'b1;
                    end
                end
            end
            ISSUE: begin
                wd_d = 16'd0;
                if (TIMEOUT_CYCLES == 1) begin
                    expire = 1'b1;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // done is checked first so a completion on the final cycle still wins
                if (done) begin
                    if (posted_q) begin
                        state_d = IDLE;
                    end else begin
                        mem_ready_d = 1'b1;
                        mem_rdata_d = (cmd == CMD_WRITE) ? 32'h0 : result;
                        state_d     = RESP;
                    end
                end else if (wd_q == WD_LAST) begin
                    expire = 1'b1;
                end else begin
                    wd_d = wd_q + 16'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            DRAIN: begin
                if (done) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (expire) begin
            timeout_err_d = 1'b1;
            state_d       = DRAIN;
            if (!posted_q) begin
                mem_ready_d = 1'b1;
                mem_rdata_d = 32'hFFFF_FFFF;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= IDLE;
            wd_q        <= 16'd0;
            posted_q    <= 1'b0;
            mem_ready   <= 1'b0;
            mem_rdata   <= 32'h0;
            start       <= 1'b0;
            cmd         <= 8'h0;
            addr_out    <= 32'h0;
            data_out    <= 32'h0;
            wstrb_out   <= 4'h0;
            oor_err     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state_q     <= state_d;
            wd_q        <= wd_d;
            posted_q    <= posted_d;
            mem_ready   <= mem_ready_d;
            mem_rdata   <= mem_rdata_d;
            start       <= start_d;
            cmd         <= cmd_d;
            addr_out    <= addr_out_d;
            data_out    <= data_out_d;
            wstrb_out   <= wstrb_out_d;
            oor_err     <= oor_err_d;
            timeout_err <= timeout_err_d;
        end
    end

endmodule

// File: tb/tb_sram_cpu_bridge.sv
// Randomized bench for sram_cpu_bridge: a transaction-level model predicts the cycle of every
// start, acknowledge and error pulse; an adapter model answers each start after a chosen latency.
module tb_sram_cpu_bridge;

    localparam logic [31:0] BASE = 32'h0000_0000;
    localparam logic [31:0] SIZE = 32'h0008_0000;
    localparam int          TMO  = 8;
`ifdef SRAM_POSTED_WRITE_EN
    localparam bit POSTED = 1'b1;
`else
    localparam bit POSTED = 1'b0;
`endif

    logic        clk;
    logic        resetn;
    logic        mem_valid;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        start;
    logic [7:0]  cmd;
    logic [31:0] addr_out;
    logic [31:0] data_out;
    logic [3:0]  wstrb_out;
    logic        busy   = 1'b0;
    logic        done   = 1'b0;
    logic [31:0] result = 32'h0;
    logic        oor_err;
    logic        timeout_err;

    sram_cpu_bridge #(
        .ADDR_BASE(BASE),
        .ADDR_SIZE(SIZE),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .mem_valid(mem_valid),
        .mem_instr(mem_instr),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb),
        .mem_ready(mem_ready),
        .mem_rdata(mem_rdata),
        .start(start),
        .cmd(cmd),
        .addr_out(addr_out),
        .data_out(data_out),
        .wstrb_out(wstrb_out),
        .busy(busy),
        .done(done),
        .result(result),
        .oor_err(oor_err),
        .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          c;
        int          d;
        bit          isW;
        logic [7:0]  cmd;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  ws;
    } startExp_t;

    typedef struct {
        int          c;
        logic [31:0] v;
    } evt_t;

    typedef struct {
        int          lat;
        logic [31:0] res;
    } adReq_t;

    startExp_t expStart[$];
    startExp_t holdQ[$];
    evt_t      expReady[$];
    int        expOor[$];
    int        expTo[$];
    adReq_t    adQ[$];

    int checks = 0;
    int errors = 0;
    int freeAt = 0;
    bit monEn  = 1'b0;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%h exp=%h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_pulses"}, {28'd0, mem_ready, start, oor_err, timeout_err}, 32'd0);
        checkOutput({tag, "_cmd"}, {24'd0, cmd}, 32'd0);
        checkOutput({tag, "_addr_out"}, addr_out, 32'd0);
        checkOutput({tag, "_data_out"}, data_out, 32'd0);
        checkOutput({tag, "_wstrb_out"}, {28'd0, wstrb_out}, 32'd0);
        checkOutput({tag, "_mem_rdata"}, mem_rdata, 32'd0);
    endtask

    // Transaction-level prediction: when the bridge can next accept, and what each event looks like
    task automatic predict(input int p, input logic [31:0] a, input logic [31:0] wd,
                           input logic [3:0] ws, input int lat, input logic [31:0] res);
        int        acc;
        int        s;
        int        d;
        bit        isW;
        bit        inWin;
        startExp_t se;
        evt_t      ev;
        adReq_t    ar;
        acc   = (p > freeAt) ? p : freeAt;
        inWin = (longint'(a) >= longint'(BASE)) && (longint'(a) < longint'(BASE) + longint'(SIZE));
        isW   = (ws != 4'h0);
        if (!inWin) begin
            ev.c = acc + 1;
            ev.v = 32'h0;
            expReady.push_back(ev);
            expOor.push_back(acc + 1);
            freeAt = acc + 2;
        end else begin
            s        = acc + 1;
            d        = s + lat;
            se.c     = s;
            se.d     = d;
            se.isW   = isW;
            se.cmd   = isW ? 8'h02 : 8'h03;
            se.addr  = a - BASE;
            se.data  = wd;
            se.ws    = ws;
            expStart.push_back(se);
            ar.lat = lat;
            ar.res = res;
            adQ.push_back(ar);
            if (POSTED && isW) begin
                ev.c = s;
                ev.v = 32'h0;
                expReady.push_back(ev);
                if (lat >= TMO) expTo.push_back(s + TMO);
                freeAt = d + 1;
            end else if (lat < TMO) begin
                ev.c = d + 1;
                ev.v = isW ? 32'h0 : res;
                expReady.push_back(ev);
                freeAt = d + 2;
            end else begin
                ev.c = s + TMO;
                ev.v = 32'hFFFF_FFFF;
                expReady.push_back(ev);
                expTo.push_back(s + TMO);
                freeAt = d + 1;
            end
        end
    endtask

    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                                 input int lat, input logic [31:0] res);
        bit seen;
        @(negedge clk);
        predict(cyc, a, wd, ws, lat, res);
        mem_addr  = a;
        mem_wdata = wd;
        mem_wstrb = ws;
        mem_instr = 1'($urandom_range(0, 1));
        mem_valid = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 100 && !seen; k++) begin
            @(negedge clk);
            if (mem_ready) seen = 1'b1;
        end
        if (!seen) checkOutput("ready_wait", 32'd0, 32'd1);
        mem_valid = 1'b0;
    endtask

    // Adapter model: done arrives the queued latency after each observed start
    int          doneAt = -1;
    logic [31:0] doneRes = 32'h0;
    adReq_t      adCur;
    always @(negedge clk) begin
        done   = 1'b0;
        result = ~doneRes;
        if (!resetn) begin
            doneAt = -1;
        end else begin
            if (start) begin
                if (adQ.size() != 0) begin
                    adCur   = adQ.pop_front();
                    doneAt  = cyc + adCur.lat;
                    doneRes = adCur.res;
                end else begin
                    doneAt = cyc + 30;
                end
            end
            if (cyc == doneAt) begin
                done   = 1'b1;
                result = doneRes;
                doneAt = -1;
            end
        end
        busy = (doneAt != -1);
    end

    startExp_t monSe;
    evt_t      monEv;
    int        monC;
    always @(negedge clk) begin
        if (monEn) begin
            if (start) begin
                if (expStart.size() == 0) begin
                    checkOutput("start_unexpected", 32'd1, 32'd0);
                end else begin
                    monSe = expStart.pop_front();
                    checkOutput("start_cycle", cyc, monSe.c);
                    checkOutput("start_cmd", {24'd0, cmd}, {24'd0, monSe.cmd});
                    checkOutput("start_addr", addr_out, monSe.addr);
                    checkOutput("start_wstrb", {28'd0, wstrb_out}, {28'd0, monSe.ws});
                    if (monSe.isW) checkOutput("start_data", data_out, monSe.data);
                    holdQ.push_back(monSe);
                end
            end else if (expStart.size() != 0 && expStart[0].c == cyc) begin
                checkOutput("start_missing", 32'd0, 32'd1);
                void'(expStart.pop_front());
            end

            if (holdQ.size() != 0 && holdQ[0].d == cyc) begin
                monSe = holdQ.pop_front();
                checkOutput("hold_cmd", {24'd0, cmd}, {24'd0, monSe.cmd});
                checkOutput("hold_addr", addr_out, monSe.addr);
                checkOutput("hold_wstrb", {28'd0, wstrb_out}, {28'd0, monSe.ws});
                if (monSe.isW) checkOutput("hold_data", data_out, monSe.data);
            end

            if (mem_ready) begin
                if (expReady.size() == 0) begin
                    checkOutput("ready_unexpected", 32'd1, 32'd0);
                end else begin
                    monEv = expReady.pop_front();
                    checkOutput("ready_cycle", cyc, monEv.c);
                    checkOutput("ready_rdata", mem_rdata, monEv.v);
                end
            end else if (expReady.size() != 0 && expReady[0].c == cyc) begin
                checkOutput("ready_missing", 32'd0, 32'd1);
                void'(expReady.pop_front());
            end

            if (oor_err) begin
                if (expOor.size() == 0) begin
                    checkOutput("oor_unexpected", 32'd1, 32'd0);
                end else begin
                    monC = expOor.pop_front();
                    checkOutput("oor_cycle", cyc, monC);
                end
            end else if (expOor.size() != 0 && expOor[0] == cyc) begin
                checkOutput("oor_missing", 32'd0, 32'd1);
                void'(expOor.pop_front());
            end

            if (timeout_err) begin
                if (expTo.size() == 0) begin
                    checkOutput("timeout_unexpected", 32'd1, 32'd0);
                end else begin
                    monC = expTo.pop_front();
                    checkOutput("timeout_cycle", cyc, monC);
                end
            end else if (expTo.size() != 0 && expTo[0] == cyc) begin
                checkOutput("timeout_missing", 32'd0, 32'd1);
                void'(expTo.pop_front());
            end
        end
    end

    task automatic checkDrained(input string tag);
        checkOutput({tag, "_starts"}, expStart.size(), 32'd0);
        checkOutput({tag, "_readys"}, expReady.size(), 32'd0);
        checkOutput({tag, "_oors"}, expOor.size() + expTo.size(), 32'd0);
    endtask

    initial begin
        #400000;
        $display("[TB] simulation time limit reached");
        $fatal(1, "[TB] time limit");
    end

    logic [31:0] rA;
    logic [31:0] rWd;
    logic [31:0] rRes;
    logic [3:0]  rWs;
    int          rLat;

    initial begin
        resetn    = 1'b0;
        mem_valid = 1'b0;
        mem_instr = 1'b0;
        mem_addr  = 32'h0;
        mem_wdata = 32'h0;
        mem_wstrb = 4'h0;

        repeat (3) @(negedge clk);
        checkAllZero("rst_hold");
        resetn = 1'b1;
        @(negedge clk);
        checkAllZero("rst_rel");
        freeAt = cyc;
        monEn  = 1'b1;

        applyStimulus(32'h0000_0100, 32'h0, 4'h0, 4, 32'hCAFE_BABE);
        applyStimulus(32'h0007_FFFC, 32'h1234_5678, 4'b0011, 3, 32'h0BAD_F00D);
        applyStimulus(32'h0008_0000, 32'h0, 4'h0, 1, 32'h0);
        applyStimulus(32'hFFFF_FFFC, 32'hAAAA_5555, 4'hF, 1, 32'h0);
        applyStimulus(32'h0007_FFFF, 32'h0, 4'h0, 2, 32'h1357_9BDF);
        applyStimulus(32'h0000_0300, 32'h0, 4'h0, 12, 32'h1111_2222);
        applyStimulus(32'h0000_0304, 32'h0, 4'h0, 2, 32'h3333_4444);
        applyStimulus(32'h0000_0308, 32'h0, 4'h0, TMO - 1, 32'h5555_6666);
        applyStimulus(32'h0000_0040, 32'hDEAD_BEEF, 4'hF, 5, 32'h0);
        applyStimulus(32'h0000_0044, 32'h0, 4'h0, 2, 32'h9999_AAAA);
        applyStimulus(32'h0000_0048, 32'h0102_0304, 4'b1000, 12, 32'h0);
        applyStimulus(32'h0000_004C, 32'h0, 4'h0, 1, 32'h2468_ACE0);

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 7) == 0)
                rA = 32'h0008_0000 + ($urandom() & 32'h7FF7_FFFC);
            else
                rA = $urandom_range(0, 32'h0007_FFFF) & 32'hFFFF_FFFC;
            rWd  = $urandom();
            rRes = $urandom();
            rWs  = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
            rLat = ($urandom_range(0, 5) == 0) ? $urandom_range(9, 14) : $urandom_range(1, 7);
            applyStimulus(rA, rWd, rWs, rLat, rRes);
        end

        repeat (30) @(negedge clk);
        checkDrained("drain_rand");

        // Reset in the middle of a read must clear every output, including held read data
        applyStimulus(32'h0000_0080, 32'h0, 4'h0, 2, 32'h5A5A_1234);
        repeat (5) @(negedge clk);
        monEn     = 1'b0;
        mem_addr  = 32'h0000_0084;
        mem_wstrb = 4'h0;
        mem_valid = 1'b1;
        repeat (4) @(negedge clk);
        resetn    = 1'b0;
        mem_valid = 1'b0;
        @(negedge clk);
        checkAllZero("rst_mid");
        resetn = 1'b1;
        adQ.delete();
        @(negedge clk);
        freeAt = cyc;
        monEn  = 1'b1;
        applyStimulus(32'h0000_0088, 32'h0, 4'h0, 3, 32'h7777_8888);
        repeat (40) @(negedge clk);
        checkDrained("drain_end");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_cpu_bridge.md
Name: sram_cpu_bridge

Overview:
Bridges the PicoRV32 native memory interface (mem_valid/mem_ready) onto the SRAM adapter's start/busy/done request port. Sits between the CPU and the SRAM adapter.
- Decodes the SRAM address window.
- Issues exactly one start pulse per in-range CPU access.
- Returns read data to the CPU.
- Guards against a hung transaction with a timeout watchdog.

Parameters:
ADDR_BASE, 32'h0000_0000, byte base address of the SRAM window
ADDR_SIZE, 32'h0008_0000, window size in bytes (512 KB = 256K x 16-bit words)
TIMEOUT_CYCLES, 255, cycles from start to done before the access is aborted (1..65535)

Ports:
clk  in  1  system clock
resetn  in  1  synchronous active-low reset
mem_valid  in  1  CPU request valid
mem_instr  in  1  CPU instruction-fetch flag (informational; no behavioural effect)
mem_addr  in  32  CPU byte address
mem_wdata  in  32  CPU write data
mem_wstrb  in  4  CPU byte strobes; 0 = read
mem_ready  out  1  one-cycle CPU acknowledge
mem_rdata  out  32  CPU read data, valid while mem_ready=1
start  out  1  one-cycle request pulse to the SRAM adapter
cmd  out  8  8'h02 for a write, 8'h03 for a read
addr_out  out  32  address minus ADDR_BASE, held from start until done
data_out  out  32  write data, held from start until done
wstrb_out  out  4  strobes, held from start until done
busy  in  1  adapter busy (rises one cycle after start; informational)
done  in  1  adapter one-cycle completion pulse
result  in  32  adapter read data, valid in the done cycle
oor_err  out  1  one-cycle pulse on an out-of-range access
timeout_err  out  1  one-cycle pulse on a watchdog abort

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-low, on resetn.
- Reset values: all outputs 0; state=IDLE; watchdog counter=0.
- Registered outputs: all outputs are registered. Only the one-cycle pulses (mem_ready, start, oor_err, timeout_err) toggle.
- States: IDLE, ISSUE, WAIT, RESP, DRAIN.
- IDLE:
  - If mem_valid and in range (ADDR_BASE <= mem_addr < ADDR_BASE+ADDR_SIZE; compare in 33 bits, no wrap): latch addr/data/wstrb/cmd and go to ISSUE.
  - If mem_valid and out of range: mem_ready=1, mem_rdata=0, oor_err=1 for one cycle. Writes are dropped. No start is issued. Stay in IDLE.
- ISSUE: start=1 for exactly one cycle; clear the watchdog counter; go to WAIT.
- WAIT:
  - Count cycles. Completion is detected on done only, never on busy falling.
  - On done: capture result into mem_rdata (writes return 0) and go to RESP.
  - If the counter reaches TIMEOUT_CYCLES without done: mem_ready=1, mem_rdata=32'hFFFF_FFFF, timeout_err=1, go to DRAIN.
- RESP: mem_ready=1 for one cycle; return to IDLE. mem_valid is re-sampled the following cycle as a new request.
- DRAIN: wait for done and discard it (no mem_ready, mem_rdata unchanged), then go to IDLE. This prevents a late done from being matched to the next request. DRAIN has no timeout.
- Latency: in-range read with mem_valid sampled at cycle 0 gives start at cycle 1 and done at cycle N. Then mem_ready is asserted at cycle N+1. Minimum CPU latency is done latency + 2.
- Simultaneous events: done in the same cycle the counter hits TIMEOUT_CYCLES counts as success (done wins).
- Request lifetime: mem_valid may drop only after mem_ready. A request present while the bridge is not in IDLE is ignored until IDLE.
- Reset mid-operation: immediate return to IDLE with all outputs 0. The adapter shares resetn, so no outstanding done is expected.

Optional Feature:
SRAM_POSTED_WRITE_EN
- Defined:
  - An in-range write is acknowledged (mem_ready=1) in the ISSUE cycle, concurrently with start, then waits for done in state WAIT.
  - A following request arriving during that WAIT is held (no mem_ready) until done, then processed from IDLE.
  - A timeout on a posted write pulses timeout_err, issues no mem_ready, and goes to DRAIN.
  - Reads behave as without the macro.
- Undefined: writes complete through RESP exactly like reads.

Test Plan:
- Reset held 3 cycles, then released -> all outputs 0, no start.
- Read at 0x0000_0100; adapter returns done 4 cycles after start with result 0xCAFEBABE -> single start with cmd=8'h03 and addr_out=0x100, then mem_ready one cycle after done with mem_rdata=0xCAFEBABE.
- Write 0x12345678, wstrb=4'b0011, addr 0x0007_FFFC -> cmd=8'h02, data_out/wstrb_out held until done, mem_ready one cycle after done.
- Access to 0x0008_0000 (first byte past the window) -> mem_ready next cycle, mem_rdata=0, oor_err=1, no start.
- TIMEOUT_CYCLES=8 with done withheld until 12 cycles after start -> timeout_err and mem_ready with 0xFFFF_FFFF at start+8. The late done produces no mem_ready. A next read issued immediately is serviced correctly.
- With SRAM_POSTED_WRITE_EN defined: write followed back-to-back by a read -> write mem_ready in the start cycle; the read's start is not issued until the write's done.
